chip8_mem: RTL and testbench

- Parametrised CHIP-8 memory subsystem: byte RAM plus a fixed font ROM overlaid on the low reserved region.
- Port A: CPU read/write with req/ack handshake.
- Port B: read-only burst port for the sprite/draw engine, streaming up to 16 bytes.
- A clear engine zeroes the user region on command. Sits between the CPU core, the draw engine and the loader.

---
 rtl/chip8_mem_pkg.sv | 40 ++++
 rtl/chip8_font_rom.sv | 27 ++
 rtl/chip8_mem.sv | 173 +++++++++++++++++
 tb/tb_chip8_mem.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/chip8_mem_pkg.sv
// CHIP-8 memory shared definitions: default geometry, font glyph table, FSM state types.
// No logic of its own; imported by the font ROM and the memory top.
package chip8_mem_pkg;

  localparam int AW_DEF         = 12;
  localparam int DW_DEF         = 8;
  localparam int RESERVED_DEF   = 512;
  localparam int FONT_BYTES_DEF = 80;
  localparam int FONT_TBL_LEN   = 80;

  // Glyphs 0..F, five rows each, upper nibble carries the pixels.
  localparam logic [7:0] FONT_TBL [0:FONT_TBL_LEN-1] = '{
    8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,
    8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
    8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,
    8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
    8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,
    8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,
    8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,
    8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,
    8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
  };

  typedef enum logic [1:0] {B_IDLE, B_ISSUE, B_STREAM} burst_state_t;
  typedef enum logic [1:0] {C_IDLE, C_CLEAR, C_DONE} clr_state_t;

  function automatic logic [7:0] font_byte(input logic [8:0] idx, input int nbytes);
    font_byte = 8'h00;
    if (int'(idx) < nbytes && int'(idx) < FONT_TBL_LEN)
      font_byte = FONT_TBL[idx[6:0]];
  endfunction

endpackage

// File: rtl/chip8_font_rom.sv
// Dual-read font ROM; one-cycle registered latency on each port, no backpressure.
// Entries past the populated glyphs read as zero.
module chip8_font_rom
  import chip8_mem_pkg::*;
#(
  parameter int DW         = DW_DEF,
  parameter int FONT_BYTES = FONT_BYTES_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [8:0]    addr0,
  input  logic [8:0]    addr1,
  output logic [DW-1:0] dat0,
  output logic [DW-1:0] dat1
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dat0 <= '0;
      dat1 <= '0;
    end else begin
      dat0 <= DW'(font_byte(addr0, FONT_BYTES));
      dat1 <= DW'(font_byte(addr1, FONT_BYTES));
    end
  end

endmodule

// File: rtl/chip8_mem.sv
// CHIP-8 RAM with font overlay: port A req/ack (1-cycle ack, held off during clear), burst port B (first beat 2 cycles after start, no backpressure), clear engine.
// CHIP8_MEM_WP_ERR_EN enables a_err on writes into the reserved region.
module chip8_mem
  import chip8_mem_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int RESERVED   = RESERVED_DEF,
  parameter int FONT_BYTES = FONT_BYTES_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_din,
  output logic          a_ack,
  output logic [DW-1:0] a_dout,
  output logic          a_err,
  input  logic          b_start,
  input  logic [AW-1:0] b_addr,
  input  logic [3:0]    b_len,
  output logic          b_valid,
  output logic [DW-1:0] b_data,
  output logic          b_last,
  output logic          b_busy,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic          clr_done
);

  localparam logic [AW-1:0] RES_A = AW'(RESERVED);

  logic [DW-1:0] mem [0:(2**AW)-1];
  logic [DW-1:0] ram_q0, ram_q1, rom_q0, rom_q1;
  logic          a_sel_q, b_sel_q;

  clr_state_t    c_state;
  logic [AW-1:0] clr_addr;
  logic          clr_we;

  burst_state_t  b_state;
  logic [AW-1:0] b_ptr;
  logic [4:0]    b_rem;
  logic          b_issue;

  logic          a_acc, a_rsv, p0_we;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdat;

  // A waits out its own ack cycle and any clear sweep.
  assign a_rsv   = (a_addr < RES_A);
  assign a_acc   = a_req && !a_ack && !clr_busy;
  assign clr_we  = (c_state == C_CLEAR);
  assign p0_we   = clr_we || (a_acc && a_we && !a_rsv);
  assign p0_addr = clr_we ? clr_addr : a_addr;
  assign p0_wdat = clr_we ? '0 : a_din;
  assign b_issue = (b_state == B_ISSUE) || (b_state == B_STREAM && b_rem != 5'd0);

  chip8_font_rom #(.DW(DW), .FONT_BYTES(FONT_BYTES)) u_font (
    .clk   (clk),
    .reset (reset),
    .addr0 (a_addr[8:0]),
    .addr1 (b_ptr[8:0]),
    .dat0  (rom_q0),
    .dat1  (rom_q1)
  );

  // Read-before-write: a B read colliding with a port-0 write sees the old byte.
  always_ff @(posedge clk) begin
    if (p0_we)
      mem[p0_addr] <= p0_wdat;
    ram_q0 <= mem[a_addr];
    ram_q1 <= mem[b_ptr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_ack   <= 1'b0;
      a_sel_q <= 1'b0;
      b_sel_q <= 1'b0;
    end else begin
      a_ack   <= a_acc;
      a_sel_q <= a_rsv;
      b_sel_q <= (b_ptr < RES_A);
    end
  end

  assign a_dout = a_ack   ? (a_sel_q ? rom_q0 : ram_q0) : '0;
  assign b_data = b_valid ? (b_sel_q ? rom_q1 : ram_q1) : '0;

`ifdef CHIP8_MEM_WP_ERR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) a_err <= 1'b0;
    else       a_err <= a_acc && a_we && a_rsv;
  end
`else
  assign a_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_state  <= C_IDLE;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
      clr_addr <= RES_A;
    end else begin
      case (c_state)
        C_IDLE: begin
          clr_done <= 1'b0;
          if (clr_start) begin
            c_state  <= C_CLEAR;
            clr_busy <= 1'b1;
            clr_addr <= RES_A;
          end
        end
        C_CLEAR: begin
          if (clr_addr == '1) begin
            c_state  <= C_DONE;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        default: begin
          c_state  <= C_IDLE;
          clr_done <= 1'b0;
        end
      endcase
    end
  end

  // Beats leave the RAM one cycle after issue; STREAM with nothing left drains the last beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b_state <= B_IDLE;
      b_busy  <= 1'b0;
      b_valid <= 1'b0;
      b_last  <= 1'b0;
      b_ptr   <= '0;
      b_rem   <= 5'd0;
    end else begin
      b_valid <= b_issue;
      b_last  <= b_issue && (b_rem == 5'd1);
      case (b_state)
        B_IDLE: begin
          if (b_start) begin
            b_state <= B_ISSUE;
            b_busy  <= 1'b1;
            b_ptr   <= b_addr;
            b_rem   <= (b_len == 4'd0) ? 5'd16 : {1'b0, b_len};
          end
        end
        B_ISSUE: begin
          b_state <= B_STREAM;
          b_ptr   <= b_ptr + 1'b1;
          b_rem   <= b_rem - 5'd1;
        end
        default: begin
          if (b_rem != 5'd0) begin
            b_ptr <= b_ptr + 1'b1;
            b_rem <= b_rem - 5'd1;
          end else begin
            b_state <= B_IDLE;
            b_busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chip8_mem.sv
// Directed bench for chip8_mem: font reads, protected writes, bursts incl. wrap and len=0, clear timing and reset abort.
module tb_chip8_mem;

  logic        clk, reset;
  logic        a_req, a_we, a_ack, a_err;
  logic [11:0] a_addr;
  logic [7:0]  a_din, a_dout;
  logic        b_start, b_valid, b_last, b_busy;
  logic [11:0] b_addr;
  logic [3:0]  b_len;
  logic [7:0]  b_data;
  logic        clr_start, clr_busy, clr_done;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int last_cnt = 0;

`ifdef CHIP8_MEM_WP_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  chip8_mem dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
    .a_ack(a_ack), .a_dout(a_dout), .a_err(a_err),
    .b_start(b_start), .b_addr(b_addr), .b_len(b_len),
    .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_busy(b_busy),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (clr_done === 1'b1) done_cnt++;
    if (b_last === 1'b1) last_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic a_op(input logic we, input logic [11:0] addr, input logic [7:0] din,
                      input int max_wait, output int lat, output logic ack,
                      output logic [7:0] dout, output logic err);
    a_req = 1'b1; a_we = we; a_addr = addr; a_din = din; lat = 0;
    do begin
      tick();
      lat++;
    end while (a_ack !== 1'b1 && lat < max_wait);
    ack = a_ack; dout = a_dout; err = a_err;
    a_req = 1'b0; a_we = 1'b0;
    tick();
  endtask

  task automatic rd(input string tag, input logic [11:0] addr, input logic [7:0] exp);
    int lat; logic ack, err; logic [7:0] d;
    a_op(1'b0, addr, 8'h00, 4, lat, ack, d, err);
    chkn({tag, "_lat"}, lat, 1);
    chk1({tag, "_ack"}, ack, 1'b1);
    chk8({tag, "_dat"}, d, exp);
    chk1({tag, "_err"}, err, 1'b0);
  endtask

  task automatic wr(input string tag, input logic [11:0] addr, input logic [7:0] din, input logic exp_err);
    int lat; logic ack, err; logic [7:0] d;
    a_op(1'b1, addr, din, 4, lat, ack, d, err);
    chk1({tag, "_ack"}, ack, 1'b1);
    chk1({tag, "_err"}, err, exp_err);
  endtask

  // exp holds beats left-aligned, first beat in the top byte.
  task automatic burst(input logic [11:0] addr, input logic [3:0] len, input logic [127:0] exp, input int n);
    b_addr = addr; b_len = len; b_start = 1'b1;
    tick();
    b_start = 1'b0;
    chk1("b_busy_t1", b_busy, 1'b1);
    chk1("b_valid_t1", b_valid, 1'b0);
    for (int i = 0; i < n; i++) begin
      tick();
      chk1($sformatf("b_valid_%0d", i), b_valid, 1'b1);
      chk8($sformatf("b_data_%0d", i), b_data, exp[127-8*i -: 8]);
      chk1($sformatf("b_last_%0d", i), b_last, (i == n-1));
      chk1($sformatf("b_busy_%0d", i), b_busy, 1'b1);
    end
    tick();
    chk1("b_busy_end", b_busy, 1'b0);
    chk1("b_valid_end", b_valid, 1'b0);
  endtask

  initial begin
    int lat, n, snap_d, snap_l;
    logic ack, err;
    logic [7:0] d;

    reset = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_din = '0;
    b_start = 1'b0; b_addr = '0; b_len = '0; clr_start = 1'b0;
    repeat (3) tick();
    chk1("rst_a_ack", a_ack, 1'b0);
    chk8("rst_a_dout", a_dout, 8'h00);
    chk1("rst_a_err", a_err, 1'b0);
    chk1("rst_b_valid", b_valid, 1'b0);
    chk8("rst_b_data", b_data, 8'h00);
    chk1("rst_b_last", b_last, 1'b0);
    chk1("rst_b_busy", b_busy, 1'b0);
    chk1("rst_clr_busy", clr_busy, 1'b0);
    chk1("rst_clr_done", clr_done, 1'b0);
    reset = 1'b0;
    tick();

    rd("rd000", 12'h000, 8'hF0);
    rd("rd04f", 12'h04F, 8'h80);
    rd("rd050", 12'h050, 8'h00);
    wr("wr200", 12'h200, 8'hA5, 1'b0);
    rd("rd200", 12'h200, 8'hA5);
    wr("wr100", 12'h100, 8'h55, EXP_ERR);
    rd("rd100", 12'h100, 8'h00);
    wr("wrffe", 12'hFFE, 8'h3C, 1'b0);
    wr("wrfff", 12'hFFF, 8'hC3, 1'b0);

    burst(12'h00A, 4'd5, {40'hF010F080F0, 88'h0}, 5);
    burst(12'hFFE, 4'd4, {32'h3CC3F090, 96'h0}, 4);
    burst(12'h000, 4'd0, 128'hF0909090F02060202070F010F080F0F0, 16);

    // Read and clear launched together: the read wins, the clear follows.
    wr("wr300", 12'h300, 8'h12, 1'b0);
    snap_d = done_cnt;
    a_req = 1'b1; a_we = 1'b0; a_addr = 12'h300; clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    chk1("clr_race_ack", a_ack, 1'b1);
    chk8("clr_race_dat", a_dout, 8'h12);
    chk1("clr_race_busy", clr_busy, 1'b1);
    a_req = 1'b0;
    tick();
    a_op(1'b0, 12'h300, 8'h00, 4000, lat, ack, d, err);
    chkn("stall_lat", lat, 3584);
    chk1("stall_ack", ack, 1'b1);
    chk8("stall_dat", d, 8'h00);
    chkn("clr_done_once", done_cnt - snap_d, 1);
    rd("post_clr000", 12'h000, 8'hF0);
    rd("post_clr200", 12'h200, 8'h00);
    rd("post_clrfff", 12'hFFF, 8'h00);

    // Reset in the middle of a clear and a burst.
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (96) tick();
    b_addr = 12'h000; b_len = 4'd0; b_start = 1'b1;
    tick();
    b_start = 1'b0;
    repeat (2) tick();
    chk1("mid_b_valid", b_valid, 1'b1);
    chk1("mid_clr_busy", clr_busy, 1'b1);
    snap_d = done_cnt; snap_l = last_cnt;
    reset = 1'b1;
    #1;
    chk1("abort_clr_busy", clr_busy, 1'b0);
    chk1("abort_b_busy", b_busy, 1'b0);
    chk1("abort_b_valid", b_valid, 1'b0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (5) tick();
    chkn("abort_no_done", done_cnt - snap_d, 0);
    chkn("abort_no_last", last_cnt - snap_l, 0);

    snap_d = done_cnt;
    clr_start = 1'b1; n = 0;
    do begin
      tick();
      clr_start = 1'b0;
      n++;
    end while (clr_done !== 1'b1 && n < 4000);
    chk1("reclr_done", clr_done, 1'b1);
    chkn("reclr_cycles", n, 3585);
    chk1("reclr_busy", clr_busy, 1'b0);
    tick();
    chk1("reclr_pulse", clr_done, 1'b0);
    chkn("reclr_done_cnt", done_cnt - snap_d, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
